// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared constants and types for the registered ALU control decoder and
//   its mult/div sequencer: ALU control codes, alu_op encodings, R-type
//   funct values, HI/LO select codes, mult/div op and sequencer state enums.
package alu_ctrl_pkg;

  // ALU control codes (low 4 bits of alu_ctl)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // alu_op encodings from the main decoder
  localparam logic [1:0] AOP_MEM   = 2'b00;
  localparam logic [1:0] AOP_BR    = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_ORI   = 2'b11;

  // R-type funct field values
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // HI/LO move select
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  // Instructions that either start the mult/div unit or read its result;
  // these must wait while an earlier mult/div is pending or in flight.
  function automatic logic is_md_hazard(input logic [1:0] aop, input logic [5:0] f);
    return (aop == AOP_RTYPE) &&
           ((f[5:2] == 4'b0110) || (f == F_MFHI) || (f == F_MFLO));
  endfunction

endpackage

// File: rtl/alu_control_seq_md_sequencer.sv
// md_sequencer
//   Tracks the iterative mult/div unit. Leaves IDLE when a mult/div entry is
//   handed to EX and stays BUSY for MD_LAT cycles.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | no mult/div in flight
//   S_BUSY | mult/div executing; r_cnt counts remaining cycles down to 0
//
// Ports
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   i_xfer     in  output entry transfers downstream this edge
//   i_entry_md in  a valid mult/div entry is held in the output register
//   o_md_busy  out mult/div pending (held) or in flight
module md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_xfer,
  input  logic i_entry_md,
  output logic o_md_busy
);

  localparam int CNT_W = $clog2(MD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_xfer && i_entry_md) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_md_busy = i_entry_md | (r_state == S_BUSY);

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq
//   Registered, valid/ready ALU control decoder between ID and EX. Decodes
//   alu_op/funct into an ALU control code plus mult/div and HI/LO sideband,
//   holds one entry, and stalls mult/div-dependent requests while the
//   iterative mult/div unit is busy.
//
//   Build option: ALU_MULDIV_EN -- when defined, mult/div and MFHI/MFLO decode,
//   the md_sequencer and the hazard stall are compiled in. When undefined,
//   those functs decode as illegal and md_start/md_op/hilo_sel/md_busy are 0.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   upstream handshake from ID
//   alu_op, funct       instruction decode inputs
//   out_valid/out_ready downstream handshake to EX
//   alu_ctl             ALU control code (zero-extended to ALUCTL_W)
//   md_start, md_op     held entry is a mult/div and which kind
//   hilo_sel            01 MFHI, 10 MFLO, 00 none
//   illegal             R-type with an undefined funct
//   md_busy             mult/div pending or in flight
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 4,
  parameter int MD_LAT   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          alu_op,
  input  logic [5:0]          funct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                md_start,
  output logic [1:0]          md_op,
  output logic [1:0]          hilo_sel,
  output logic                illegal,
  output logic                md_busy
);

  logic       w_accept;
  logic       w_xfer;
  logic [3:0] w_code;
  logic       w_illegal;

  logic       r_out_valid;
  logic [3:0] r_alu_ctl;
  logic       r_illegal;

`ifdef ALU_MULDIV_EN
  logic       w_md;
  md_op_t     w_md_op;
  logic [1:0] w_hilo;
  logic       w_hazard;
  logic       w_md_busy;
  logic       r_md_start;
  md_op_t     r_md_op;
  logic [1:0] r_hilo;
`endif

  always_comb begin
    w_code    = ALU_ADD;
    w_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
    w_md      = 1'b0;
    w_md_op   = MD_MULT;
    w_hilo    = HILO_NONE;
`endif
    case (alu_op)
      AOP_MEM: w_code = ALU_ADD;
      AOP_BR:  w_code = ALU_SUB;
      AOP_ORI: w_code = ALU_OR;
      default: begin
        case (funct)
          F_ADD, F_ADDU: w_code = ALU_ADD;
          F_SUB, F_SUBU: w_code = ALU_SUB;
          F_AND:         w_code = ALU_AND;
          F_OR:          w_code = ALU_OR;
          F_XOR:         w_code = ALU_XOR;
          F_NOR:         w_code = ALU_NOR;
          F_SLT:         w_code = ALU_SLT;
          F_SLTU:        w_code = ALU_SLTU;
`ifdef ALU_MULDIV_EN
          // mult/div and HI/LO moves keep the ADD code; EX steers on sideband
          F_MULT:  begin w_md = 1'b1; w_md_op = MD_MULT;  end
          F_MULTU: begin w_md = 1'b1; w_md_op = MD_MULTU; end
          F_DIV:   begin w_md = 1'b1; w_md_op = MD_DIV;   end
          F_DIVU:  begin w_md = 1'b1; w_md_op = MD_DIVU;  end
          F_MFHI:  w_hilo = HILO_HI;
          F_MFLO:  w_hilo = HILO_LO;
`endif
          default:       w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_xfer = r_out_valid & out_ready;

`ifdef ALU_MULDIV_EN
  assign w_hazard = is_md_hazard(alu_op, funct);
  assign in_ready = (!r_out_valid | out_ready) & !(w_md_busy & w_hazard);

  md_sequencer #(
    .MD_LAT (MD_LAT)
  ) u_md_seq (
    .clk        (clk),
    .rst        (rst),
    .i_xfer     (w_xfer),
    .i_entry_md (r_out_valid & r_md_start),
    .o_md_busy  (w_md_busy)
  );
`else
  assign in_ready = !r_out_valid | out_ready;
`endif

  assign w_accept = in_valid & in_ready;

  // Single-entry output register; an accept in the same edge as a transfer
  // simply overwrites the departing entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_alu_ctl   <= '0;
      r_illegal   <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_md_start  <= 1'b0;
      r_md_op     <= MD_MULT;
      r_hilo      <= HILO_NONE;
`endif
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_ctl   <= w_code;
      r_illegal   <= w_illegal;
`ifdef ALU_MULDIV_EN
      r_md_start  <= w_md;
      r_md_op     <= w_md_op;
      r_hilo      <= w_hilo;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctl   = ALUCTL_W'(r_alu_ctl);
  assign illegal   = r_illegal;

`ifdef ALU_MULDIV_EN
  assign md_start  = r_md_start;
  assign md_op     = r_md_op;
  assign hilo_sel  = r_hilo;
  assign md_busy   = w_md_busy;
`else
  assign md_start  = 1'b0;
  assign md_op     = 2'b00;
  assign hilo_sel  = 2'b00;
  assign md_busy   = 1'b0;
`endif

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked successor to the single-cycle ALU control decoder for the multicycle/pipelined MIPS core. Decodes `alu_op`/`funct` into a 4-bit ALU control code and adds the extended R-type set (ADDU, SUBU, XOR, NOR, SLTU). It also sequences the iterative multiply/divide unit, stalling dependent instructions until the result is ready. The block sits between the ID stage (upstream valid/ready) and the EX stage (downstream valid/ready).

## Interface
- `ALUCTL_W`, default 4: width of the ALU control code; must be ≥4.
- `MD_LAT`, default 32: mult/div unit latency in cycles; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at a rising edge.
- `alu_op` in 2: 00 load/store, 01 branch, 10 R-type, 11 ORI.
- `funct` in 6: instruction funct field, used only when `alu_op`=10.
- `out_valid` out 1: output entry held.
- `out_ready` in 1: downstream accepts the entry when `out_valid & out_ready`.
- `alu_ctl` out `ALUCTL_W`: ALU control code, upper bits beyond 4 zero.
- `md_start` out 1: held entry is a mult/div instruction.
- `md_op` out 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `hilo_sel` out 2: 01 MFHI, 10 MFLO, 00 none.
- `illegal` out 1: R-type with an undefined funct.
- `md_busy` out 1: mult/div in flight or pending.

## Operation
- Code map (low 4 bits of `alu_ctl`):
  - `alu_op` 00 → 0010.
  - `alu_op` 01 → 0110.
  - `alu_op` 11 → 0001.
  - R-type funct 100000/100001 → 0010; 100010/100011 → 0110; 100100 → 0000; 100101 → 0001; 100110 → 0011; 100111 → 1100; 101010 → 0111; 101011 → 0101.
  - Funct 011000–011011 (mult/div) and 010000/010010 (MFHI/MFLO) → 0010, with `md_op`/`hilo_sel` set.
  - Any other R-type funct → 0010 with `illegal`=1. The entry still passes downstream.
- Single-entry output register; all sideband outputs (`md_start`, `md_op`, `hilo_sel`, `illegal`) are registered with the entry.
- Hazard (combinational on the inputs): `alu_op`=10 and funct is mult/div or MFHI/MFLO.
- `in_ready` = (!`out_valid` | `out_ready`) & !(`md_busy` & hazard).
- Mult/div FSM:
  - IDLE: a mult/div entry transfers downstream → BUSY, counter ← `MD_LAT`-1.
  - BUSY: counter = 0 → IDLE at the next edge; otherwise decrement.
  - A mult/div entry held but not yet transferred counts as pending.
- `md_busy` = pending | (state == BUSY).
- Non-hazard instructions flow freely while BUSY.

## Timing
- Latency: acceptance at edge k → `out_valid`=1 after edge k. Full throughput of one request per cycle while `out_ready`=1.
- Back-pressure: with `out_valid`=1 and `out_ready`=0, the entry and all outputs hold stable and `in_ready`=0.
- `md_busy` stays high from the held mult/div entry through `MD_LAT` cycles after its transfer edge.
- A stalled hazard request is accepted in the first cycle `md_busy` is 0.
- Simultaneous transfer and accept: the new entry replaces the old one in the same edge.
- Reset, asynchronous and at any time, including mid-BUSY:
  - State returns to IDLE, counter to 0.
  - `out_valid`, `md_start`, `md_busy`, `illegal` = 0.
  - `alu_ctl`, `md_op`, `hilo_sel` = 0.
  - No in-flight entry survives reset.

## Configuration
- `ALU_MULDIV_EN` defined: mult/div decode, FSM and counter compiled in, as described above.
- `ALU_MULDIV_EN` undefined:
  - Mult/div and MFHI/MFLO functs decode as illegal (code 0010, `illegal`=1).
  - `md_start`, `md_op`, `hilo_sel`, `md_busy` tied 0.
  - Hazard term removed from `in_ready`.

## Structure
- Package `alu_ctrl_pkg` holds:
  - ALU code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU).
  - Funct constants.
  - `md_op_t` enum.
  - Sequencer state enum (S_IDLE, S_BUSY).
- Sub-module `md_sequencer`: FSM plus `$clog2(MD_LAT+1)`-bit counter. Inputs: transfer strobe, entry-is-md. Output: `md_busy`.

## Test plan
- Reset then `alu_op`=10, funct 101010, `out_ready`=1 → after 1 cycle `out_valid`=1, `alu_ctl`=0111, `illegal`=0.
- Back-to-back ADD, XOR (100110), SLTU (101011) with `out_ready`=1 → codes 0010, 0011, 0101 on consecutive cycles, `in_ready` stays 1.
- MULT (011000) with `MD_LAT`=4, then MFLO held valid:
  - `md_start`=1, `md_op`=00.
  - `md_busy` high through 4 cycles after the transfer.
  - MFLO is accepted on the first cycle `md_busy`=0; then `hilo_sel`=10.
- Funct 111111 → `alu_ctl`=0010, `illegal`=1. Hold `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0.
- Assert `rst` mid-BUSY (DIVU, 2 cycles in) → same cycle `md_busy`=0, `out_valid`=0. After release, a new MULTU is accepted immediately.
- Build without `ALU_MULDIV_EN` → MULT decodes with `illegal`=1, `md_busy` remains 0.
